// File: rtl/rx_scramble_seq.sv
// rx_scramble_seq -- receive-side scrambler sequencer.
// Watches the decoded 8b/10b symbol stream, recognises SKP, FTS, EIOS and
// TS1/TS2 ordered sets, and drives the descrambler LFSR controls
// (reset, advance, apply) with one cycle of latency so they line up with
// the registered datapath byte.
// Optional feature macro: RX_SCRAMBLE_SEQ_EIOS_EN
//   defined   -> EIOS is detected, pulses ElecIdleOrderedSet and parks the
//                block in UNLOCK with the scrambler held in reset until
//                Synced falls and rises again.
//   undefined -> ElecIdleOrderedSet stays 0 and COM+IDL is an unknown set.

module rx_scramble_seq (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] DecodeByte,
    input  logic       DecodeCtrl,
    input  logic       Synced,
    input  logic       DisableScramble,
    output logic       notResetScrambler,
    output logic       MoveScrambler,
    output logic       Scramble,
    output logic       SkpOrderedSet,
    output logic       FtsOrderedSet,
    output logic       ElecIdleOrderedSet,
    output logic [1:0] RxTrainingSeq
);

    localparam logic [7:0] K_COM  = 8'hBC;
    localparam logic [7:0] K_SKP  = 8'h1C;
    localparam logic [7:0] K_FTS  = 8'h3C;
    localparam logic [7:0] K_IDL  = 8'h7C;
    localparam logic [7:0] D_TS1  = 8'h4A;
    localparam logic [7:0] D_TS2  = 8'h45;

    typedef enum logic [1:0] {
        UNLOCK  = 2'd0,
        DATA    = 2'd1,
        OS_TYPE = 2'd2,
        OS_BODY = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SET_SKP  = 2'd0,
        SET_FTS  = 2'd1,
        SET_EIOS = 2'd2,
        SET_TS   = 2'd3
    } set_t;

    // True when the sampled symbol is the given code with the given K/D flag.
    function automatic logic symIs(input logic ctrl, input logic [7:0] sym,
                                   input logic wantCtrl, input logic [7:0] code);
        return (ctrl == wantCtrl) && (sym == code);
    endfunction

    state_t     state_r, nextState_s;
    set_t       set_r, nextSet_s;
    logic [3:0] symCnt_r, nextCnt_s;
    logic       tsIsTs2_r, nextTs2_s;
    logic       eiosHold_r, nextHold_s;
    logic       eiosSawLow_r, nextSawLow_s;

    logic       isCom_s, isSkp_s, isFts_s, isIdl_s;
    logic       asData_s;
    logic       nRst_s, move_s, scr_s, skp_s, fts_s, eios_s;
    logic [1:0] ts_s;
    logic [7:0] tsId_s;

    assign isCom_s = symIs(DecodeCtrl, DecodeByte, 1'b1, K_COM);
    assign isSkp_s = symIs(DecodeCtrl, DecodeByte, 1'b1, K_SKP);
    assign isFts_s = symIs(DecodeCtrl, DecodeByte, 1'b1, K_FTS);
    assign isIdl_s = symIs(DecodeCtrl, DecodeByte, 1'b1, K_IDL);
    assign tsId_s  = tsIsTs2_r ? D_TS2 : D_TS1;

    // Next-state and next-output decode for the symbol sampled this cycle.
    always_comb begin
        nextState_s  = state_r;
        nextSet_s    = set_r;
        nextCnt_s    = symCnt_r;
        nextTs2_s    = tsIsTs2_r;
        nextHold_s   = eiosHold_r;
        nextSawLow_s = eiosSawLow_r;
        asData_s     = 1'b0;
        nRst_s       = 1'b1;
        move_s       = 1'b0;
        scr_s        = 1'b0;
        skp_s        = 1'b0;
        fts_s        = 1'b0;
        eios_s       = 1'b0;
        ts_s         = 2'b00;

        if (!Synced) begin
            // Loss of lock beats everything; any set in flight is dropped.
            nextState_s = UNLOCK;
            nextCnt_s   = 4'd0;
            if (eiosHold_r) begin
                nextSawLow_s = 1'b1;
            end else begin
                nextSawLow_s = eiosSawLow_r;
            end
            nRst_s = ~eiosHold_r;
        end else begin
            case (state_r)
                UNLOCK: begin
                    if (eiosHold_r && !eiosSawLow_r) begin
                        nextState_s = UNLOCK;
                        nRst_s      = 1'b0;
                    end else begin
                        nextState_s  = DATA;
                        nextCnt_s    = 4'd0;
                        nextHold_s   = 1'b0;
                        nextSawLow_s = 1'b0;
                    end
                end
                DATA: begin
                    asData_s = 1'b1;
                end
                OS_TYPE: begin
                    move_s = ~isSkp_s;
                    if (isCom_s) begin
                        asData_s = 1'b1;
                    end else if (isSkp_s) begin
                        nextState_s = OS_BODY;
                        nextSet_s   = SET_SKP;
                        nextCnt_s   = 4'd2;
                    end else if (isFts_s) begin
                        nextState_s = OS_BODY;
                        nextSet_s   = SET_FTS;
                        nextCnt_s   = 4'd2;
`ifdef RX_SCRAMBLE_SEQ_EIOS_EN
                    end else if (isIdl_s) begin
                        nextState_s = OS_BODY;
                        nextSet_s   = SET_EIOS;
                        nextCnt_s   = 4'd2;
`endif
                    end else if (!DecodeCtrl) begin
                        nextState_s = OS_BODY;
                        nextSet_s   = SET_TS;
                        nextCnt_s   = 4'd2;
                    end else begin
                        nextState_s = DATA;
                        nextCnt_s   = 4'd0;
                    end
                end
                OS_BODY: begin
                    move_s = ~isSkp_s;
                    if (set_r == SET_SKP) begin
                        // SKP runs end on the first other symbol, which is
                        // then handled as an ordinary data-state symbol.
                        if (isSkp_s) begin
                            nextState_s = OS_BODY;
                        end else begin
                            skp_s    = 1'b1;
                            asData_s = 1'b1;
                        end
                    end else if (isCom_s) begin
                        asData_s = 1'b1;
                    end else begin
                        case (set_r)
                            SET_FTS: begin
                                if (isFts_s) begin
                                    if (symCnt_r == 4'd3) begin
                                        fts_s       = 1'b1;
                                        nextState_s = DATA;
                                        nextCnt_s   = 4'd0;
                                    end else begin
                                        nextCnt_s = symCnt_r + 4'd1;
                                    end
                                end else begin
                                    nextState_s = DATA;
                                    nextCnt_s   = 4'd0;
                                end
                            end
                            SET_EIOS: begin
`ifdef RX_SCRAMBLE_SEQ_EIOS_EN
                                if (isIdl_s) begin
                                    if (symCnt_r == 4'd3) begin
                                        eios_s       = 1'b1;
                                        nRst_s       = 1'b0;
                                        nextState_s  = UNLOCK;
                                        nextCnt_s    = 4'd0;
                                        nextHold_s   = 1'b1;
                                        nextSawLow_s = 1'b0;
                                    end else begin
                                        nextCnt_s = symCnt_r + 4'd1;
                                    end
                                end else begin
                                    nextState_s = DATA;
                                    nextCnt_s   = 4'd0;
                                end
`else
                                nextState_s = DATA;
                                nextCnt_s   = 4'd0;
`endif
                            end
                            SET_TS: begin
                                if (symCnt_r < 4'd6) begin
                                    nextCnt_s = symCnt_r + 4'd1;
                                end else if (symCnt_r == 4'd6) begin
                                    // Symbol 6 fixes which identifier the rest must repeat.
                                    if (symIs(DecodeCtrl, DecodeByte, 1'b0, D_TS1)) begin
                                        nextTs2_s = 1'b0;
                                        nextCnt_s = 4'd7;
                                    end else if (symIs(DecodeCtrl, DecodeByte, 1'b0, D_TS2)) begin
                                        nextTs2_s = 1'b1;
                                        nextCnt_s = 4'd7;
                                    end else begin
                                        nextState_s = DATA;
                                        nextCnt_s   = 4'd0;
                                    end
                                end else if (symIs(DecodeCtrl, DecodeByte, 1'b0, tsId_s)) begin
                                    if (symCnt_r == 4'd15) begin
                                        ts_s        = tsIsTs2_r ? 2'b10 : 2'b01;
                                        nextState_s = DATA;
                                        nextCnt_s   = 4'd0;
                                    end else begin
                                        nextCnt_s = symCnt_r + 4'd1;
                                    end
                                end else begin
                                    nextState_s = DATA;
                                    nextCnt_s   = 4'd0;
                                end
                            end
                            default: begin
                                nextState_s = DATA;
                                nextCnt_s   = 4'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    nextState_s = UNLOCK;
                    nextCnt_s   = 4'd0;
                end
            endcase

            // Data-state handling: COM opens a set and resets the LFSR,
            // any other D symbol is descrambled unless the link disables it.
            if (asData_s) begin
                move_s = ~isSkp_s;
                if (isCom_s) begin
                    nextState_s = OS_TYPE;
                    nextCnt_s   = 4'd1;
                    nRst_s      = 1'b0;
                end else begin
                    nextState_s = DATA;
                    nextCnt_s   = 4'd0;
                    scr_s       = ~DecodeCtrl & ~DisableScramble;
                end
            end else begin
                nextState_s = nextState_s;
            end
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r            <= UNLOCK;
            set_r              <= SET_SKP;
            symCnt_r           <= 4'd0;
            tsIsTs2_r          <= 1'b0;
            eiosHold_r         <= 1'b0;
            eiosSawLow_r       <= 1'b0;
            notResetScrambler  <= 1'b0;
            MoveScrambler      <= 1'b0;
            Scramble           <= 1'b0;
            SkpOrderedSet      <= 1'b0;
            FtsOrderedSet      <= 1'b0;
            ElecIdleOrderedSet <= 1'b0;
            RxTrainingSeq      <= 2'b00;
        end else begin
            state_r            <= nextState_s;
            set_r              <= nextSet_s;
            symCnt_r           <= nextCnt_s;
            tsIsTs2_r          <= nextTs2_s;
            eiosHold_r         <= nextHold_s;
            eiosSawLow_r       <= nextSawLow_s;
            notResetScrambler  <= nRst_s;
            MoveScrambler      <= move_s;
            Scramble           <= scr_s;
            SkpOrderedSet      <= skp_s;
            FtsOrderedSet      <= fts_s;
            ElecIdleOrderedSet <= eios_s;
            RxTrainingSeq      <= ts_s;
        end
    end

endmodule
